// File: rtl/fir_hls_div_pkg.sv
// Shared widths, saturation limits and FSM states for the sequential
// signed-by-unsigned divider used in the folded FIR datapath.
package fir_hls_div_pkg;

    localparam int DIN0_W = 27;           // signed dividend (product) width
    localparam int DIN1_W = 11;           // unsigned divisor (coefficient) width
    localparam int DOUT_W = 16;           // signed quotient (sample) width
    localparam int REM_W  = DIN1_W + 1;   // partial remainder absorbs one shift bit
    localparam int CNT_W  = $clog2(DIN0_W);

    localparam logic [DOUT_W-1:0] QMAX = 16'h7FFF;
    localparam logic [DOUT_W-1:0] QMIN = 16'h8000;

    // Largest quotient magnitudes representable for each sign.
    localparam logic [DIN0_W-1:0] QMAG_POS = DIN0_W'((2 ** (DOUT_W - 1)) - 1);
    localparam logic [DIN0_W-1:0] QMAG_NEG = DIN0_W'(2 ** (DOUT_W - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/fir_hls_div_27s_11ns_16_seq_if.sv
// Operand/result handshake bundle for the sequential divider.
interface fir_hls_div_27s_11ns_16_seq_if;
    import fir_hls_div_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DIN0_W-1:0] din0;
    logic [DIN1_W-1:0] din1;
    logic              out_valid;
    logic              out_ready;
    logic [DOUT_W-1:0] quot;
    logic [REM_W-1:0]  rem;
    logic              ovf;
    logic              dbz;

    // Upstream/downstream side: supplies operands and consumes results.
    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, quot, rem, ovf, dbz
    );

    // Divider side.
    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, quot, rem, ovf, dbz
    );

endinterface

// File: rtl/fir_hls_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit and
// subtract the divisor when it fits.
module fir_hls_div_step
    import fir_hls_div_pkg::*;
(
    input  logic [DIN1_W-1:0] part_i,   // current partial remainder (always < divisor)
    input  logic              bit_i,    // next dividend magnitude bit, MSB first
    input  logic [DIN1_W-1:0] div_i,
    output logic [REM_W-1:0]  part_o,
    output logic              qbit_o
);

    logic [REM_W-1:0] shifted;

    // Compare-and-restore on the widened shifted remainder.
    always_comb begin
        shifted = {part_i, bit_i};
        part_o  = shifted;
        qbit_o  = 1'b0;
        if (shifted >= {1'b0, div_i}) begin
            part_o = shifted - {1'b0, div_i};
            qbit_o = 1'b1;
        end
    end

endmodule

// File: rtl/fir_hls_div_27s_11ns_16_seq.sv
// Sequential 27s / 11u divider producing a saturated 16-bit signed quotient
// and an exact remainder, one quotient bit per cycle.
module fir_hls_div_27s_11ns_16_seq
    import fir_hls_div_pkg::*;
(
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    fir_hls_div_27s_11ns_16_seq_if.slave  bus
);

    div_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DIN0_W-1:0] mag_q;     // dividend magnitude, becomes quotient magnitude
    logic              sign_q;
    logic [DIN1_W-1:0] div_q;
    logic [REM_W-1:0]  part_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [DOUT_W-1:0] quot_q;
    logic [REM_W-1:0]  rem_q;
    logic              ovf_q;
    logic              dbz_q;

    logic [DIN0_W-1:0] mag_in;
    logic [REM_W-1:0]  part_d;
    logic              qbit_d;
    logic [DOUT_W-1:0] quot_d;
    logic [REM_W-1:0]  rem_d;
    logic              ovf_d;
    logic              dbz_d;

    // |din0| as an unsigned value so that -2^26 maps cleanly to 2^26.
    assign mag_in = bus.din0[DIN0_W-1] ? (~bus.din0 + DIN0_W'(1)) : bus.din0;

    fir_hls_div_step u_step (
        .part_i (part_q[DIN1_W-1:0]),
        .bit_i  (mag_q[DIN0_W-1]),
        .div_i  (div_q),
        .part_o (part_d),
        .qbit_o (qbit_d)
    );

    // Sign restoration, saturation and divide-by-zero override.
    always_comb begin
        quot_d = mag_q[DOUT_W-1:0];
        ovf_d  = 1'b0;
        dbz_d  = 1'b0;
        rem_d  = sign_q ? (~part_q + REM_W'(1)) : part_q;
        if (div_q == '0) begin
            quot_d = sign_q ? QMIN : QMAX;
            rem_d  = '0;
            ovf_d  = 1'b1;
            dbz_d  = 1'b1;
        end else if (!sign_q) begin
            if (mag_q > QMAG_POS) begin
                quot_d = QMAX;
                ovf_d  = 1'b1;
            end
        end else begin
            if (mag_q > QMAG_NEG) begin
                quot_d = QMIN;
                ovf_d  = 1'b1;
            end else begin
                quot_d = ~mag_q[DOUT_W-1:0] + DOUT_W'(1);
            end
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mag_q       <= '0;
            sign_q      <= 1'b0;
            div_q       <= '0;
            part_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        mag_q      <= mag_in;
                        sign_q     <= bus.din0[DIN0_W-1];
                        div_q      <= bus.din1;
                        part_q     <= '0;
                        cnt_q      <= CNT_W'(DIN0_W - 1);
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    mag_q  <= {mag_q[DIN0_W-2:0], qbit_d};
                    part_q <= part_d;
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                FIX: begin
                    quot_q      <= quot_d;
                    rem_q       <= rem_d;
                    ovf_q       <= ovf_d;
                    dbz_q       <= dbz_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.quot      = quot_q;
    assign bus.rem       = rem_q;
    assign bus.ovf       = ovf_q;
    assign bus.dbz       = dbz_q;

endmodule

// File: tb/tb_fir_hls_div_27s_11ns_16_seq.sv
// Scoreboard bench for the sequential divider: expected results come from an
// integer model, are queued at operand accept and compared at result time.
module tb_fir_hls_div_27s_11ns_16_seq;
    import fir_hls_div_pkg::*;

    logic ap_clk = 1'b0;
    logic ap_rst;

    always #5 ap_clk = ~ap_clk;

    fir_hls_div_27s_11ns_16_seq_if bus ();

    fir_hls_div_27s_11ns_16_seq dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    typedef struct {
        longint quot;
        longint rem;
        longint ovf;
        longint dbz;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input longint a, input longint b);
        exp_t   e;
        longint q;
        e.ovf = 0;
        e.dbz = 0;
        if (b == 0) begin
            e.quot = (a < 0) ? -32768 : 32767;
            e.rem  = 0;
            e.ovf  = 1;
            e.dbz  = 1;
        end else begin
            q     = a / b;
            e.rem = a % b;
            if (q > 32767) begin
                q     = 32767;
                e.ovf = 1;
            end else if (q < -32768) begin
                q     = -32768;
                e.ovf = 1;
            end
            e.quot = q;
        end
        return e;
    endfunction

    // Drive one operation, check latency, optional hold in DONE, and result.
    task automatic run_op(input longint a, input longint b, input int hold,
                          input bit keep_valid, input bit expect_immediate);
        int          n;
        int          lat;
        exp_t        e;
        logic [15:0] q0;
        logic [11:0] r0;
        bus.din0     = 27'(a);
        bus.din1     = 11'(b);
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        if (n >= 100) begin
            check_val("accept_timeout", n, 0);
            bus.in_valid = 1'b0;
            return;
        end
        if (expect_immediate) check_val("accept_wait", n, 0);
        sb.push_back(model(a, b));
        @(posedge ap_clk);
        #1;
        if (!keep_valid) bus.in_valid = 1'b0;
        @(negedge ap_clk);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(negedge ap_clk);
            lat++;
        end
        check_val("latency_edges", lat, 28);
        if (!bus.out_valid) begin
            void'(sb.pop_front());
            return;
        end
        q0 = bus.quot;
        r0 = bus.rem;
        for (int i = 0; i < hold; i++) begin
            @(negedge ap_clk);
            check_val("hold_out_valid", longint'(bus.out_valid), 1);
            check_val("hold_in_ready", longint'(bus.in_ready), 0);
            check_val("hold_quot", longint'(bus.quot), longint'(q0));
            check_val("hold_rem", longint'(bus.rem), longint'(r0));
        end
        e = sb.pop_front();
        $display("op din0=%0d din1=%0d quot=%0d rem=%0d ovf=%0d dbz=%0d exp_quot=%0d exp_rem=%0d",
                 a, b, $signed(bus.quot), $signed(bus.rem), bus.ovf, bus.dbz, e.quot, e.rem);
        check_val("quot", longint'($signed(bus.quot)), e.quot);
        check_val("rem", longint'($signed(bus.rem)), e.rem);
        check_val("ovf", longint'(bus.ovf), e.ovf);
        check_val("dbz", longint'(bus.dbz), e.dbz);
        bus.out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge ap_clk);
        check_val("post_out_valid", longint'(bus.out_valid), 0);
        check_val("post_in_ready", longint'(bus.in_ready), 1);
    endtask

    // Absolute time limit so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen_valid;
        ap_rst        = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.din0      = '0;
        bus.din1      = '0;
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check_val("rst_in_ready", longint'(bus.in_ready), 1);
        check_val("rst_out_valid", longint'(bus.out_valid), 0);
        check_val("rst_quot", longint'(bus.quot), 0);
        check_val("rst_rem", longint'(bus.rem), 0);
        check_val("rst_ovf", longint'(bus.ovf), 0);
        check_val("rst_dbz", longint'(bus.dbz), 0);

        run_op(-1000, 7, 0, 1'b0, 1'b0);
        run_op(-1234000, 1000, 0, 1'b0, 1'b0);
        run_op(-67076096, 2047, 0, 1'b0, 1'b0);
        run_op(5000000, 3, 0, 1'b0, 1'b0);
        run_op(-5000000, 3, 0, 1'b0, 1'b0);
        run_op(100, 0, 0, 1'b0, 1'b0);
        run_op(-1, 0, 0, 1'b0, 1'b0);
        run_op(0, 5, 0, 1'b0, 1'b0);
        run_op(-67108864, 1, 0, 1'b0, 1'b0);
        run_op(32767, 1, 0, 1'b0, 1'b0);
        run_op(-65537, 2, 0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            longint a;
            longint b;
            a = longint'($signed(27'($urandom)));
            b = longint'($urandom_range(1, 2047));
            run_op(a, b, 0, 1'b0, 1'b0);
        end

        // Backpressure with in_valid held high, then immediate next accept.
        run_op(123456, 17, 5, 1'b1, 1'b0);
        run_op(-999, 10, 0, 1'b0, 1'b1);

        // Reset in the middle of the iteration.
        bus.din0     = 27'(1000000);
        bus.din1     = 11'(3);
        bus.in_valid = 1'b1;
        @(posedge ap_clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge ap_clk);
        #1;
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check_val("midrst_out_valid", longint'(bus.out_valid), 0);
        check_val("midrst_in_ready", longint'(bus.in_ready), 1);
        seen_valid = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge ap_clk);
            if (bus.out_valid) seen_valid++;
        end
        check_val("midrst_no_result", seen_valid, 0);
        run_op(49, 7, 0, 1'b0, 1'b1);

        check_val("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
